// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : round-robin arbiter of cache I/D ports onto a single RAM port.
// Optional access watchdog enabled by defining MEM_ARB_WATCHDOG_EN.
// Rev 1.0
// ============================================================================
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ack,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_was_d_q, last_was_d_d;
  logic        ram_ren_q, ram_ren_d;
  logic        ram_wen_q, ram_wen_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_store_q, ram_store_d;

  logic d_pend;
  logic done;
  logic drop;
  logic timeout;

  assign d_pend = dREN | dWEN;
  // A completion is never signalled in a cycle that is being reset.
  assign done   = (state_q != IDLE) && ram_ack && !RST;
  assign drop   = ((state_q == IACC) && !iREN) || ((state_q == DACC) && !d_pend);

`ifdef MEM_ARB_WATCHDOG_EN
  logic [6:0] cnt_q, cnt_d;

  assign timeout = (state_q != IDLE) && (cnt_q == 7'(TIMEOUT));
  assign err     = timeout && !ram_ack && !RST;

  always_comb begin
    cnt_d = '0;
    if (state_q != IDLE) begin
      cnt_d = cnt_q + 7'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT != 0);
  assign timeout        = 1'b0;
  assign err            = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_was_d_d = last_was_d_q;
    ram_ren_d    = ram_ren_q;
    ram_wen_d    = ram_wen_q;
    ram_addr_d   = ram_addr_q;
    ram_store_d  = ram_store_q;
    case (state_q)
      IDLE: begin
        // On a tie the port that was not served last wins.
        if (d_pend && (!iREN || !last_was_d_q)) begin
          state_d     = DACC;
          ram_wen_d   = dWEN;
          ram_ren_d   = !dWEN;
          ram_addr_d  = daddr;
          ram_store_d = dstore;
        end else if (iREN) begin
          state_d    = IACC;
          ram_ren_d  = 1'b1;
          ram_wen_d  = 1'b0;
          ram_addr_d = iaddr;
        end
      end
      IACC, DACC: begin
        if (ram_ack) begin
          state_d      = IDLE;
          ram_ren_d    = 1'b0;
          ram_wen_d    = 1'b0;
          last_was_d_d = (state_q == DACC);
        end else if (drop || timeout) begin
          state_d   = IDLE;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        ram_ren_d = 1'b0;
        ram_wen_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      last_was_d_q <= 1'b0;
      ram_ren_q    <= 1'b0;
      ram_wen_q    <= 1'b0;
      ram_addr_q   <= '0;
      ram_store_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_was_d_q <= last_was_d_d;
      ram_ren_q    <= ram_ren_d;
      ram_wen_q    <= ram_wen_d;
      ram_addr_q   <= ram_addr_d;
      ram_store_q  <= ram_store_d;
    end
  end

  assign iwait    = !(done && (state_q == IACC));
  assign dwait    = !(done && (state_q == DACC));
  assign iload    = ramload;
  assign dload    = ramload;
  assign ramREN   = ram_ren_q;
  assign ramWEN   = ram_wen_q;
  assign ramaddr  = ram_addr_q;
  assign ramstore = ram_store_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: directed scenarios with literal expectations, plus an
// access-level model of the arbiter compared against the DUT every cycle.
module tb_mem_arbiter;
  localparam int TIMEOUT = 8;
`ifdef MEM_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, ram_ack = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ack(ram_ack), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one in-flight access record plus the identity of the last port served.
  bit          m_act = 0, m_isd = 0, m_wr = 0, m_last_d = 0;
  logic [31:0] m_addr = '0, m_store = '0;
  int          m_age = 0;

  always @(posedge CLK) begin
    if (RST) begin
      m_act = 0; m_isd = 0; m_wr = 0; m_last_d = 0;
      m_addr = '0; m_store = '0; m_age = 0;
    end else if (!m_act) begin
      if ((dREN || dWEN) && (!iREN || !m_last_d)) begin
        m_act = 1; m_isd = 1; m_wr = dWEN; m_addr = daddr; m_store = dstore; m_age = 0;
      end else if (iREN) begin
        m_act = 1; m_isd = 0; m_wr = 0; m_addr = iaddr; m_age = 0;
      end
    end else if (ram_ack) begin
      m_act = 0; m_last_d = m_isd;
    end else if ((m_isd ? !(dREN || dWEN) : !iREN) || (WD && m_age == TIMEOUT)) begin
      m_act = 0;
    end else begin
      m_age++;
    end
  end

  always @(negedge CLK) begin : cmp
    logic ei, ed;
    if (cmp_en) begin
      ei = !(m_act && !m_isd && ram_ack && !RST);
      ed = !(m_act && m_isd && ram_ack && !RST);
      chk("m_iwait", iwait, ei);
      chk("m_dwait", dwait, ed);
      chk("m_ramREN", ramREN, m_act && !m_wr);
      chk("m_ramWEN", ramWEN, m_act && m_wr);
      chk("m_ramaddr", ramaddr, m_addr);
      chk("m_ramstore", ramstore, m_store);
      chk("m_err", err, WD && m_act && (m_age == TIMEOUT) && !ram_ack && !RST);
      if (!ei) chk("m_iload", iload, ramload);
      if (!ed) chk("m_dload", dload, ramload);
    end
  end

  task automatic cyc(); @(posedge CLK); #1; endtask
  task automatic mid(); @(negedge CLK); endtask
  task automatic idle_in(); iREN = 0; dREN = 0; dWEN = 0; ram_ack = 0; endtask
  task automatic do_reset(); cyc(); RST = 1; idle_in(); cyc(); RST = 0; endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ramREN"}, ramREN, 0);
    chk({tag, "_ramWEN"}, ramWEN, 0);
    chk({tag, "_ramaddr"}, ramaddr, 0);
    chk({tag, "_ramstore"}, ramstore, 0);
    chk({tag, "_iwait"}, iwait, 1);
    chk({tag, "_dwait"}, dwait, 1);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    cmp_en = 1;
    cyc(); mid();
    chk_reset_vals("rst");
    cyc(); RST = 0;

    // Read latency; address change mid-access must be ignored
    iREN = 1; iaddr = 32'h40; mid();
    chk("rd_iwait_c0", iwait, 1);
    for (int c = 1; c <= 3; c++) begin
      cyc();
      if (c == 2) iaddr = 32'h44;
      if (c == 3) begin ram_ack = 1; ramload = 32'hDEADBEEF; end
      mid();
      chk("rd_ramREN", ramREN, 1);
      chk("rd_ramaddr", ramaddr, 32'h40);
      chk("rd_iwait", iwait, (c != 3));
    end
    chk("rd_iload", iload, 32'hDEADBEEF);
    cyc(); idle_in(); mid();
    chk("rd_ramREN_after", ramREN, 0);

    // Priority after reset: D, I, D, I
    do_reset();
    iREN = 1; dREN = 1; iaddr = 32'h100; daddr = 32'h200; mid();
    for (int c = 1; c <= 8; c++) begin
      cyc();
      ram_ack = (c % 2 == 1);
      ramload = 32'hA000_0000 + c;
      if (c == 8) idle_in();
      mid();
      if (c % 2 == 1) begin
        chk("rr_ramaddr", ramaddr, (c % 4 == 1) ? 32'h200 : 32'h100);
        chk("rr_dwait", dwait, (c % 4 != 1));
        chk("rr_iwait", iwait, (c % 4 != 3));
      end
    end

    // Write with dREN|dWEN, requester drops in the ack cycle
    cyc(); dREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'h1234; mid();
    cyc(); mid();
    chk("wr_ramWEN", ramWEN, 1);
    chk("wr_ramREN", ramREN, 0);
    chk("wr_ramstore", ramstore, 32'h1234);
    chk("wr_ramaddr", ramaddr, 32'h80);
    chk("wr_dwait_c1", dwait, 1);
    cyc(); dREN = 0; dWEN = 0; ram_ack = 1; mid();
    chk("wr_dwait_ack", dwait, 0);
    cyc(); ram_ack = 0; mid();
    chk("wr_ramWEN_after", ramWEN, 0);

    // Abort by dropping dREN, then a fresh instruction grant proves IDLE
    cyc(); dREN = 1; daddr = 32'h300; mid();
    for (int c = 1; c <= 5; c++) begin
      cyc();
      if (c == 2) dREN = 0;
      if (c == 4) begin iREN = 1; iaddr = 32'h310; end
      mid();
      chk("ab_dwait", dwait, 1);
      chk("ab_ramREN", ramREN, (c <= 2) || (c == 5));
    end
    chk("ab_ramaddr", ramaddr, 32'h310);
    cyc(); idle_in(); mid();

    // Reset mid-access; a later ack is ignored
    do_reset();
    iREN = 1; iaddr = 32'h500; mid();
    cyc(); mid();
    chk("rm_ramREN_c1", ramREN, 1);
    cyc(); RST = 1; mid();
    cyc(); RST = 0; iREN = 0; mid();
    chk_reset_vals("rm");
    cyc(); ram_ack = 1; ramload = 32'h55; mid();
    chk("rm_iwait_ack", iwait, 1);
    chk("rm_dwait_ack", dwait, 1);
    chk("rm_ramREN_ack", ramREN, 0);
    cyc(); ram_ack = 0;

    // Watchdog (abort at cycle 9 when enabled, otherwise waits forever)
    iREN = 1; iaddr = 32'h600; mid();
    for (int c = 1; c <= 11; c++) begin
      cyc(); mid();
      chk("wd_err", err, WD && (c == 9));
      chk("wd_ramREN", ramREN, !(WD && (c == 10)));
    end
    cyc(); idle_in();
    cyc(); mid();
    chk("wd_ramREN_end", ramREN, 0);

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
